// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared FSM state and shift-direction encodings for shift_sequencer.
package shift_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/shift_sequencer_auto_tick.sv
// auto_tick: idle-time period counter emitting a one-cycle expiry pulse (SHIFT_SEQ_AUTOSCROLL_EN only).
module auto_tick #(
  parameter int PERIOD = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_run,
  output logic o_tick
);
  localparam int CW = $clog2(PERIOD + 1);
  logic [CW-1:0] r_cnt;
  assign o_tick = i_en && i_run && (r_cnt == CW'(PERIOD - 1));
  always_ff @(posedge clk) begin
    if (rst || !i_en) r_cnt <= '0;
    else if (i_run) r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences load/shift pulses for a display shift register with digit-offset limits.
// Optional auto-scroll is built only when SHIFT_SEQ_AUTOSCROLL_EN is defined.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int STEP = 4,
  parameter int MAX_OFS = 4,
  parameter int AUTO_PERIOD = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_req,
  input  logic [WIDTH-1:0]        load_val,
  input  logic                    left_req,
  input  logic                    right_req,
  input  logic                    auto_en,
  output logic                    sr_en,
  output logic                    sr_dir,
  output logic                    sr_load,
  output logic [WIDTH-1:0]        sr_num,
  output logic                    busy,
  output logic signed [3:0]       offset,
  output logic                    limit_hit
);
  localparam int SW = $clog2(STEP + 1);
  localparam logic signed [3:0] MAX = 4'(MAX_OFS);
  localparam logic signed [3:0] MIN = -MAX;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_held;
  logic signed [3:0] r_ofs;
  logic [SW-1:0] r_step;
  logic r_dir, r_limit;
  logic w_tick, w_idle, w_user, w_load, w_left, w_right, w_acc_l, w_acc_r, w_lim, w_last;
`ifdef SHIFT_SEQ_AUTOSCROLL_EN
  auto_tick #(.PERIOD(AUTO_PERIOD)) u_tick (
    .clk(clk), .rst(rst), .i_en(auto_en), .i_run(r_state == IDLE), .o_tick(w_tick)
  );
`else
  logic w_unused_auto;
  assign w_unused_auto = auto_en;
  assign w_tick = 1'b0;
`endif
  // user requests always win over an auto-scroll expiry in the same cycle
  always_comb begin
    w_idle  = r_state == IDLE;
    w_user  = load_req | left_req | right_req;
    w_load  = w_idle & (load_req | (w_tick & !w_user & (r_ofs == MAX)));
    w_left  = w_idle & ((left_req & !right_req & !load_req) | (w_tick & !w_user & (r_ofs != MAX)));
    w_right = w_idle & right_req & !left_req & !load_req;
    w_acc_l = w_left & (r_ofs < MAX);
    w_acc_r = w_right & (r_ofs > MIN);
    w_lim   = (w_left & !w_acc_l) | (w_right & !w_acc_r);
    w_last  = r_step == SW'(STEP - 1);
    w_next  = w_idle ? (w_load ? LOAD : (w_acc_l | w_acc_r) ? SHIFT : IDLE)
            : r_state == LOAD ? IDLE : (w_last ? IDLE : SHIFT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_held  <= '0;
      r_ofs   <= '0;
      r_step  <= '0;
      r_dir   <= DIR_LEFT;
      r_limit <= 1'b0;
    end else begin
      r_state <= w_next;
      r_limit <= w_lim;
      if (w_idle && load_req) r_held <= load_val;
      if (w_load) r_ofs <= '0;
      if (w_acc_l || w_acc_r) r_dir <= w_acc_r ? DIR_RIGHT : DIR_LEFT;
      if (r_state == SHIFT) begin
        r_step <= w_last ? '0 : r_step + 1'b1;
        if (w_last) r_ofs <= (r_dir == DIR_RIGHT) ? r_ofs - 4'sd1 : r_ofs + 4'sd1;
      end
    end
  end
  assign sr_en     = r_state == SHIFT;
  assign sr_load   = r_state == LOAD;
  assign busy      = r_state != IDLE;
  assign sr_dir    = r_dir;
  assign sr_num    = r_held;
  assign offset    = r_ofs;
  assign limit_hit = r_limit;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized scoreboard bench; expected pulse events are queued per request and popped by a monitor.
module tb_shift_sequencer;
  localparam int STEP = 4;
  localparam int MAX = 4;
  typedef struct {int kind; int val;} ev_t;
  logic clk = 0, rst = 1, load_req = 0, left_req = 0, right_req = 0, auto_en = 0;
  logic [19:0] load_val = '0;
  logic sr_en, sr_dir, sr_load, busy, limit_hit;
  logic [19:0] sr_num;
  logic signed [3:0] offset;
  ev_t q[$];
  int vecs = 0, errs = 0, m_ofs = 0, m_held = 0;

  shift_sequencer #(.WIDTH(20), .STEP(STEP), .MAX_OFS(MAX), .AUTO_PERIOD(8)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .load_val(load_val), .left_req(left_req),
    .right_req(right_req), .auto_en(auto_en), .sr_en(sr_en), .sr_dir(sr_dir), .sr_load(sr_load),
    .sr_num(sr_num), .busy(busy), .offset(offset), .limit_hit(limit_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // kinds: 0 shift pulse (val = dir), 1 load pulse (val = number), 2 limit pulse
  always @(negedge clk) begin : mon
    ev_t e;
    int k;
    if (sr_en || sr_load || limit_hit) begin
      k = sr_load ? 1 : limit_hit ? 2 : 0;
      if (q.size() == 0) chk("unexpected_event", k, -1);
      else begin
        e = q.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_data", k == 1 ? int'(sr_num) : k == 0 ? int'(sr_dir) : 0, e.val);
      end
    end
  end

  task automatic push_steps(input int dir);
    for (int i = 0; i < STEP; i++) q.push_back('{0, dir});
  endtask

  task automatic req(input logic l, input logic lf, input logic rt, input logic [19:0] v, input logic drop);
    int exp_n, n;
    exp_n = 0;
    if (l) begin
      q.push_back('{1, int'(v)});
      m_held = int'(v);
      m_ofs = 0;
      exp_n = 1;
    end else if (lf ^ rt) begin
      if (lf ? m_ofs < MAX : m_ofs > -MAX) begin
        push_steps(rt ? 1 : 0);
        m_ofs += lf ? 1 : -1;
        exp_n = STEP;
      end else q.push_back('{2, 0});
    end
    load_req = l; left_req = lf; right_req = rt; load_val = v;
    @(posedge clk); #1;
    load_req = 0; left_req = 0; right_req = 0;
    n = 0;
    if (drop && exp_n > 0) begin
      right_req = 1; load_req = 1; load_val = 20'hFFFFF;
      @(posedge clk); #1;
      right_req = 0; load_req = 0;
      n = 1;
    end
    while (busy && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", n, exp_n);
    @(posedge clk); #1;
    chk("offset", int'(offset), m_ofs);
    chk("busy_idle", int'(busy), 0);
    chk("sr_num", int'(sr_num), m_held);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sr_en"}, int'(sr_en), 0);
    chk({tag, "_sr_load"}, int'(sr_load), 0);
    chk({tag, "_sr_dir"}, int'(sr_dir), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_offset"}, int'(offset), 0);
    chk({tag, "_limit"}, int'(limit_hit), 0);
    chk({tag, "_sr_num"}, int'(sr_num), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_zero("reset");
    req(1, 0, 0, 20'h12345, 0);
    req(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) req(0, 1, 0, 0, 0);
    req(0, 1, 1, 0, 0);
    req(1, 1, 0, 20'hABCDE, 0);
    req(0, 0, 1, 0, 1);
    req(0, 1, 0, 0, 1);
    // abort a shift on its second pulse; requests during reset are ignored
    push_steps(0);
    left_req = 1;
    @(posedge clk); #1;
    left_req = 0;
    @(posedge clk); #1;
    rst = 1; left_req = 1; load_req = 1;
    @(posedge clk); #1;
    rst = 0; left_req = 0; load_req = 0;
    q.delete();
    m_ofs = 0; m_held = 0;
    chk_zero("midreset");
    @(posedge clk); #1;
    chk_zero("postreset");
    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0: req(1, 0, 0, 20'($urandom), 0);
        1, 2, 3: req(0, 1, 0, 0, 0);
        4, 5, 6: req(0, 0, 1, 0, 0);
        7: req(0, 1, 1, 0, 0);
        8: req(1, r[0], !r[0], 20'($urandom), 0);
        default: req(0, 1, 0, 0, 1);
      endcase
    end
`ifdef SHIFT_SEQ_AUTOSCROLL_EN
    begin
      int t;
      req(1, 0, 0, 20'h0BEEF, 0);
      for (int i = 0; i < 6; i++) begin
        if (m_ofs < MAX) begin
          push_steps(0);
          m_ofs++;
        end else begin
          q.push_back('{1, m_held});
          m_ofs = 0;
        end
      end
      auto_en = 1;
      t = 0;
      while (q.size() != 0 && t < 400) begin
        t++;
        @(posedge clk); #1;
      end
      while (busy && t < 420) begin
        t++;
        @(posedge clk); #1;
      end
      auto_en = 0;
      @(posedge clk); #1;
      chk("auto_drained", q.size(), 0);
      chk("auto_offset", int'(offset), m_ofs);
      chk("auto_busy", int'(busy), 0);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
